// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_add_ctrl
// Description : Digit-serial packed-BCD adder controller. It latches two
//               DIGITS-wide operands on start, then adds one digit per clock,
//               least-significant first, rippling the decimal carry through a
//               register. It reports the sum, the final carry and a sticky
//               invalid-digit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4,
   parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err,
   output logic [IDX_W-1:0]      digit_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [4*DIGITS-1:0]   r_a;
   logic [4*DIGITS-1:0]   r_b;
   logic                  r_carry;
   logic [4*DIGITS-1:0]   r_sum;
   logic                  r_cout;
   logic                  r_err;
   logic [IDX_W-1:0]      r_idx;

   logic                  w_accept;
   logic                  w_last;
   logic [3:0]            w_a_dig;
   logic [3:0]            w_b_dig;
   logic [4:0]            w_t;
   logic [4:0]            w_t_adj;
   logic [3:0]            w_s;
   logic                  w_c;
   logic                  w_bad_dig;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_last   = (r_idx == c_last_idx);

   // Digit pair currently selected by the index register
   assign w_a_dig  = r_a[{r_idx, 2'b00} +: 4];
   assign w_b_dig  = r_b[{r_idx, 2'b00} +: 4];

   // One-digit BCD adder: binary add, then +6 correction when above 9.
   // Invalid input digits still go through the same correction unchanged.
   assign w_t       = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_carry};
   assign w_t_adj   = w_t + 5'd6;
   assign w_c       = (w_t > 5'd9);
   assign w_s       = w_c ? w_t_adj[3:0] : w_t[3:0];
   assign w_bad_dig = (w_a_dig > 4'd9) || (w_b_dig > 4'd9);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_next = ST_ADD;
         ST_ADD:  if (w_last) w_state_next = ST_DONE;
         ST_DONE:             w_state_next = ST_IDLE;
         default:             w_state_next = ST_IDLE;
      endcase
   end

   // Operand capture, digit-serial accumulation and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_carry <= cin;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
      end else if (r_state == ST_ADD) begin
         r_sum[{r_idx, 2'b00} +: 4] <= w_s;
         r_carry                    <= w_c;
         if (w_bad_dig) begin
            r_err <= 1'b1;
         end
         if (w_last) begin
            r_cout <= w_c;
         end else begin
            r_idx  <= r_idx + 1'b1;
         end
      end else if (r_state == ST_DONE) begin
         r_idx <= '0;
      end
   end

   assign busy      = (r_state == ST_ADD);
   assign done      = (r_state == ST_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign err       = r_err;
   assign digit_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_add_ctrl
// Description : Directed self-checking bench for the digit-serial BCD adder
//               controller with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;

   localparam int DIGITS = 4;
   localparam int IDX_W  = 2;
   localparam int TMO    = 20;

   logic                clk;
   logic                rst;
   logic                start;
   logic [4*DIGITS-1:0] a;
   logic [4*DIGITS-1:0] b;
   logic                cin;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] sum;
   logic                cout;
   logic                err;
   logic [IDX_W-1:0]    digit_idx;

   int                  n_checks;
   int                  n_pass;
   logic [15:0]         hist [0:TMO];
   int                  lat;
   int                  busy_cyc;
   int                  done_cnt;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .err       (err),
      .digit_idx (digit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count a comparison and report any mismatch
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one start and follow the operation until done (bounded).
   // On return we sit at the falling edge of the done cycle.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         output int o_lat, output int o_busy);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      o_lat  = 0;
      o_busy = 0;
      while (!done && o_lat < TMO) begin
         if (busy) o_busy++;
         hist[o_lat] = sum;
         @(negedge clk);
         o_lat++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_sum",  {16'b0, sum},  32'd0);
      chk("rst_cout", {31'b0, cout}, 32'd0);
      chk("rst_err",  {31'b0, err},  32'd0);
      chk("rst_idx",  {30'b0, digit_idx}, 32'd0);
      rst = 1'b0;

      // 0000 + 0000
      run_op(16'h0000, 16'h0000, 1'b0, lat, busy_cyc);
      chk("zero_lat",  lat, 32'd4);
      chk("zero_sum",  {16'b0, sum},  32'h0000);
      chk("zero_cout", {31'b0, cout}, 32'd0);
      chk("zero_err",  {31'b0, err},  32'd0);

      // 1234 + 5678 with per-digit progression
      run_op(16'h1234, 16'h5678, 1'b0, lat, busy_cyc);
      chk("add_lat",   lat, 32'd4);
      chk("add_busy",  busy_cyc, 32'd4);
      chk("add_h0",    {16'b0, hist[0]}, 32'h0000);
      chk("add_h1",    {16'b0, hist[1]}, 32'h0002);
      chk("add_h2",    {16'b0, hist[2]}, 32'h0012);
      chk("add_h3",    {16'b0, hist[3]}, 32'h0912);
      chk("add_sum",   {16'b0, sum},  32'h6912);
      chk("add_cout",  {31'b0, cout}, 32'd0);
      chk("add_err",   {31'b0, err},  32'd0);
      @(negedge clk);
      chk("add_idle_busy", {31'b0, busy}, 32'd0);
      chk("add_idle_done", {31'b0, done}, 32'd0);
      chk("add_hold_sum",  {16'b0, sum},  32'h6912);
      chk("add_idle_idx",  {30'b0, digit_idx}, 32'd0);

      // Full carry ripple: 4999 + 5000 + 1
      run_op(16'h4999, 16'h5000, 1'b1, lat, busy_cyc);
      chk("rip_sum",  {16'b0, sum},  32'h0000);
      chk("rip_cout", {31'b0, cout}, 32'd1);

      // Invalid digit
      run_op(16'h00A0, 16'h0000, 1'b0, lat, busy_cyc);
      chk("bad_err",  {31'b0, err},  32'd1);
      chk("bad_sum",  {16'b0, sum},  32'h0100);
      chk("bad_cout", {31'b0, cout}, 32'd0);
      run_op(16'h0001, 16'h0001, 1'b0, lat, busy_cyc);
      chk("clr_err",  {31'b0, err},  32'd0);
      chk("clr_sum",  {16'b0, sum},  32'h0002);

      // Start during ADD is ignored
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin
            done_cnt++;
            chk("ign_sum",  {16'b0, sum},  32'h3333);
            chk("ign_cout", {31'b0, cout}, 32'd0);
         end
         @(negedge clk);
      end
      chk("ign_done_cnt", done_cnt, 32'd1);

      // Reset in the middle of ADD
      @(negedge clk);
      a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_idx",  {30'b0, digit_idx}, 32'd2);
      chk("mid_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_sum",  {16'b0, sum},  32'h0000);
      chk("mrst_cout", {31'b0, cout}, 32'd0);
      chk("mrst_idx",  {30'b0, digit_idx}, 32'd0);
      @(negedge clk);
      chk("mrst_idle_busy", {31'b0, busy}, 32'd0);
      chk("mrst_idle_done", {31'b0, done}, 32'd0);
      run_op(16'h0005, 16'h0005, 1'b0, lat, busy_cyc);
      chk("post_lat",  lat, 32'd4);
      chk("post_sum",  {16'b0, sum},  32'h0010);
      chk("post_cout", {31'b0, cout}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
